// File: rtl/cru_peri_regs.sv
// cru_peri_regs: APB3 peripheral clock/reset unit with per-channel gates, level resets and a sequenced soft-reset pulse.
// Zero-wait-state APB with pready tied 1; clk_en/srst_n lag register state by one cycle; CRU_PERI_WMASK_EN enables masked gate/reset writes.
module cru_peri_regs #(
  parameter int          NUM_CH   = 16,
  parameter int          SRST_LEN = 8,
  parameter int          GATE_DLY = 2,
  parameter logic [31:0] VERSION  = 32'h0001_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [11:0]       paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] srst_n
);

  localparam int MAXL = (SRST_LEN > GATE_DLY) ? SRST_LEN : GATE_DLY;
  localparam int CW   = $clog2(MAXL) + 1;
  localparam logic [CW-1:0] GATE_LD = CW'(GATE_DLY - 1);
  localparam logic [CW-1:0] RST_LD  = CW'(SRST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GATE = 2'd1,
    S_RST  = 2'd2,
    S_REL  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [NUM_CH-1:0] r_gate_con;
  logic [NUM_CH-1:0] r_srst_con;
  logic [NUM_CH-1:0] r_pending;
  logic [NUM_CH-1:0] r_active;
  logic [NUM_CH-1:0] w_active_nxt;
  logic [NUM_CH-1:0] w_pulse_set;
  logic              w_capture;
  logic              w_wr;
  logic              w_rd;
  logic              w_busy;
  logic              w_mapped;
  logic              w_gate_phase;
  logic              w_rst_phase;
  logic [9:0]        w_idx;
  logic [31:0]       w_rdata;
  logic              w_unused_bits;

  assign w_idx         = paddr[11:2];
  assign w_wr          = psel & penable & pwrite;
  assign w_rd          = psel & penable & ~pwrite;
  assign w_mapped      = (w_idx <= 10'd4);
  assign pready        = 1'b1;
  assign pslverr       = psel & penable & ~w_mapped;
  assign w_busy        = (r_state != S_IDLE);
  assign w_gate_phase  = (r_state == S_GATE) || (r_state == S_REL);
  assign w_rst_phase   = (r_state == S_RST);
  assign w_pulse_set   = (w_wr && (w_idx == 10'd2)) ? pwdata[NUM_CH-1:0] : '0;
  assign w_unused_bits = ^{paddr[1:0], pwdata};

  // Control registers; with the mask build, pwdata[16+i] enables the update of bit i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gate_con <= '0;
      r_srst_con <= '0;
    end else if (w_wr) begin
`ifdef CRU_PERI_WMASK_EN
      if (w_idx == 10'd0)
        r_gate_con <= (r_gate_con & ~pwdata[16 +: NUM_CH]) | (pwdata[NUM_CH-1:0] & pwdata[16 +: NUM_CH]);
      if (w_idx == 10'd1)
        r_srst_con <= (r_srst_con & ~pwdata[16 +: NUM_CH]) | (pwdata[NUM_CH-1:0] & pwdata[16 +: NUM_CH]);
`else
      if (w_idx == 10'd0)
        r_gate_con <= pwdata[NUM_CH-1:0];
      if (w_idx == 10'd1)
        r_srst_con <= pwdata[NUM_CH-1:0];
`endif
    end
  end

  // A pulse write coinciding with the IDLE capture lands in the fresh pending set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (w_capture ? '0 : r_pending) | w_pulse_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_active <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_active <= w_active_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_active_nxt = r_active;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pending != '0) begin
          w_capture    = 1'b1;
          w_active_nxt = r_pending;
          w_cnt_nxt    = GATE_LD;
          w_state_nxt  = S_GATE;
        end
      end
      S_GATE: begin
        if (r_cnt == '0) begin
          w_cnt_nxt   = RST_LD;
          w_state_nxt = S_RST;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_RST: begin
        if (r_cnt == '0) begin
          w_cnt_nxt   = GATE_LD;
          w_state_nxt = S_REL;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_REL: begin
        if (r_cnt == '0) begin
          w_active_nxt = '0;
          w_state_nxt  = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Clock stays enabled while the reset itself is asserted; it is gated only around it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_en <= '1;
      srst_n <= '1;
    end else begin
      clk_en <= ~(r_gate_con | (r_active & {NUM_CH{w_gate_phase}}));
      srst_n <= ~(r_srst_con | (r_active & {NUM_CH{w_rst_phase}}));
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_idx == 10'd0) begin
      w_rdata[NUM_CH-1:0] = r_gate_con;
    end else if (w_idx == 10'd1) begin
      w_rdata[NUM_CH-1:0] = r_srst_con;
    end else if (w_idx == 10'd2) begin
      w_rdata[NUM_CH-1:0] = r_pending;
    end else if (w_idx == 10'd3) begin
      w_rdata[NUM_CH-1:0] = r_active | r_pending;
      w_rdata[16]         = w_busy;
    end else if (w_idx == 10'd4) begin
      w_rdata = VERSION;
    end
  end

  assign prdata = w_rd ? w_rdata : '0;

endmodule

// File: tb/tb_cru_peri_regs.sv
// Self-checking bench for cru_peri_regs: directed scenarios plus random APB traffic against a timeline model.
module tb_cru_peri_regs;

  localparam int GD  = 2;
  localparam int SL  = 8;
  localparam int LEN = 2 * GD + SL;
  localparam logic [31:0] VER = 32'h0001_0000;

  logic        clk;
  logic        rst_n;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [15:0] clk_en;
  logic [15:0] srst_n;

  cru_peri_regs #(
    .NUM_CH  (16),
    .SRST_LEN(SL),
    .GATE_DLY(GD),
    .VERSION (VER)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .paddr  (paddr),
    .pwdata (pwdata),
    .prdata (prdata),
    .pready (pready),
    .pslverr(pslverr),
    .clk_en (clk_en),
    .srst_n (srst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: a sequence is a time window starting at m_start (edge entering GATE).
  logic [15:0] m_gate, m_srst, m_pend, m_act;
  bit          m_seq;
  int          m_start;
  int          cyc;
  int          lo_clk[16];
  int          lo_srst[16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] wr_field(input logic [15:0] cur, input logic [31:0] d);
`ifdef CRU_PERI_WMASK_EN
    return (cur & ~d[31:16]) | (d[15:0] & d[31:16]);
`else
    return d[15:0];
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    logic        b;
    logic [31:0] r;
    b = m_seq && ((cyc - m_start) < LEN);
    r = 32'h0;
    case (a[11:2])
      10'd0: r = {16'h0, m_gate};
      10'd1: r = {16'h0, m_srst};
      10'd2: r = {16'h0, m_pend};
      10'd3: r = {15'h0, b, (b ? m_act : 16'h0) | m_pend};
      10'd4: r = VER;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_gate = '0; m_srst = '0; m_pend = '0; m_act = '0;
    m_seq = 1'b0; m_start = 0;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 16; i++) begin
      lo_clk[i] = 0;
      lo_srst[i] = 0;
    end
  endtask

  task automatic tick();
    int          k;
    logic        gph, rph, idle_now, wr;
    logic [11:0] a;
    logic [31:0] d;
    logic [15:0] exp_clk, exp_srst;
    k        = cyc - m_start;
    gph      = m_seq && ((k < GD) || (k >= GD + SL && k < LEN));
    rph      = m_seq && (k >= GD) && (k < GD + SL);
    idle_now = !m_seq || (k >= LEN);
    exp_clk  = ~(m_gate | (gph ? m_act : 16'h0));
    exp_srst = ~(m_srst | (rph ? m_act : 16'h0));
    wr = psel && penable && pwrite;
    a  = paddr;
    d  = pwdata;
    @(posedge clk);
    cyc++;
    if (idle_now && m_pend != 16'h0) begin
      m_seq   = 1'b1;
      m_start = cyc;
      m_act   = m_pend;
      m_pend  = '0;
    end
    if (wr) begin
      case (a[11:2])
        10'd0: m_gate = wr_field(m_gate, d);
        10'd1: m_srst = wr_field(m_srst, d);
        10'd2: m_pend = m_pend | d[15:0];
        default: ;
      endcase
    end
    #1;
    chk("clk_en", {16'h0, clk_en}, {16'h0, exp_clk});
    chk("srst_n", {16'h0, srst_n}, {16'h0, exp_srst});
    for (int i = 0; i < 16; i++) begin
      if (clk_en[i] == 1'b0) lo_clk[i]++;
      if (srst_n[i] == 1'b0) lo_srst[i]++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    tick();
    penable = 1'b1;
    #1;
    chk("prdata", prdata, m_read(a));
    chk("pslverr", {31'h0, pslverr}, {31'h0, (a[11:2] > 10'd4)});
    chk("pready", {31'h0, pready}, 32'h1);
    tick();
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    int          seen;
    int          sum;
    logic [11:0] ra;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; cyc = 0;
    model_reset();
    clear_counts();

    // Reset state
    #12;
    chk("rst_clk_en", {16'h0, clk_en}, 32'h0000_FFFF);
    chk("rst_srst_n", {16'h0, srst_n}, 32'h0000_FFFF);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pslverr", {31'h0, pslverr}, 32'h0);
    chk("rst_pready", {31'h0, pready}, 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    apb_read(12'h010);
    apb_read(12'h00C);

    // Masked or plain GATE_CON write
    apb_write(12'h000, 32'h0003_00FF);
    tick();
`ifdef CRU_PERI_WMASK_EN
    chk("gate_direct", {16'h0, clk_en}, 32'h0000_FFFC);
`else
    chk("gate_direct", {16'h0, clk_en}, 32'h0000_FF00);
`endif
    apb_read(12'h000);
    apb_write(12'h000, 32'hFFFF_0000);
    idle(2);

    // Single pulse on channel 4
    clear_counts();
    apb_write(12'h008, 32'h0000_0010);
    idle(LEN + 6);
    chk("pulse_clk4_lo", lo_clk[4], 32'd4);
    chk("pulse_srst4_lo", lo_srst[4], 32'd8);
    sum = 0;
    for (int i = 0; i < 16; i++) if (i != 4) sum += lo_clk[i] + lo_srst[i];
    chk("pulse_others", sum, 32'd0);
    apb_read(12'h00C);

    // Overlap: bit 2 pended while bit 1 runs
    clear_counts();
    apb_write(12'h008, 32'h0000_0002);
    apb_write(12'h008, 32'h0000_0004);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = 12'h00C;
    tick();
    penable = 1'b1; #1;
    chk("overlap_status", prdata, 32'h0001_0006);
    tick();
    psel = 1'b0; penable = 1'b0;
    idle(2 * LEN + 6);
    chk("overlap_clk1", lo_clk[1], 32'd4);
    chk("overlap_clk2", lo_clk[2], 32'd4);
    chk("overlap_srst2", lo_srst[2], 32'd8);
    apb_read(12'h00C);

    // Unmapped and ignored low address bits
    apb_read(12'h020);
    apb_read(12'h013);

    // Reset in the middle of the RST phase
    apb_write(12'h008, 32'h0000_0008);
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      tick();
      if (srst_n[3] == 1'b0) seen = 1;
    end
    chk("midrst_seen", seen, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_clk_en", {16'h0, clk_en}, 32'h0000_FFFF);
    chk("midrst_srst_n", {16'h0, srst_n}, 32'h0000_FFFF);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(LEN + 4);
    apb_read(12'h00C);

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 5))
        0: apb_write(12'h000, $urandom);
        1: apb_write(12'h004, $urandom);
        2: apb_write(12'h008, 32'h1 << $urandom_range(0, 15));
        3: apb_write(12'h008, $urandom & 32'h0000_FFFF);
        4: begin
          ra = 12'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
          apb_read(ra);
        end
        default: idle($urandom_range(0, 6));
      endcase
    end
    apb_write(12'h000, 32'hFFFF_0000);
    apb_write(12'h004, 32'hFFFF_0000);
    idle(4 * LEN);
    apb_read(12'h00C);
    apb_read(12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
